// File: rtl/scan_addr_gen_if.sv
`default_nettype none
// scan_addr_gen_if: control inputs and decoder-facing outputs of the scan sequencer.
// Revision: 1.0
interface scan_addr_gen_if #(
  parameter int DWELL_W = 16
) ();
  logic               run;
  logic               clr;
  logic               mode;
  logic [DWELL_W-1:0] dwell;
  logic               en;
  logic [2:0]         add;
  logic               wrap;
  logic               busy;

  modport master (output run, clr, mode, dwell, input en, add, wrap, busy);
  modport slave  (input run, clr, mode, dwell, output en, add, wrap, busy);
endinterface
`default_nettype wire

// File: rtl/scan_addr_gen.sv
`default_nettype none
// scan_addr_gen: steps a 3-to-8 decoder address 0..7 with programmable dwell and blanking.
// Revision: 1.0
module scan_addr_gen #(
  parameter int DWELL_W   = 16,
  parameter int BLANK_CYC = 2,
  parameter int BLANK_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  scan_addr_gen_if.slave    bus_if
);

  localparam bit                 HAS_BLANK  = (BLANK_CYC > 0);
  localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               en_q, en_d;
  logic [2:0]         add_q, add_d;
  logic               wrap_q, wrap_d;
  logic               dir_down_q, dir_down_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [DWELL_W-1:0] dwell_lat_q, dwell_lat_d;
  logic [BLANK_W-1:0] blank_cnt_q, blank_cnt_d;

  logic [DWELL_W-1:0] dwell_eff;
  logic [2:0]         adv_add;
  logic               adv_dir_down;
  logic               pos_done;

  assign dwell_eff = (bus_if.dwell == '0) ? DWELL_W'(1) : bus_if.dwell;
  assign pos_done  = (dwell_cnt_q == dwell_lat_q - DWELL_W'(1));

  // Address the next position would take; ping-pong reflects at both ends.
  always_comb begin
    adv_add      = add_q + 3'd1;
    adv_dir_down = 1'b0;
    if (bus_if.mode) begin
      if (!dir_down_q && add_q == 3'd7) begin
        adv_add      = 3'd6;
        adv_dir_down = 1'b1;
      end else if (dir_down_q && add_q == 3'd0) begin
        adv_add      = 3'd1;
        adv_dir_down = 1'b0;
      end else if (dir_down_q) begin
        adv_add      = add_q - 3'd1;
        adv_dir_down = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    en_d        = en_q;
    add_d       = add_q;
    wrap_d      = 1'b0;
    dir_down_d  = dir_down_q;
    dwell_cnt_d = dwell_cnt_q;
    dwell_lat_d = dwell_lat_q;
    blank_cnt_d = blank_cnt_q;

    if (bus_if.clr) begin
      add_d       = 3'd0;
      dir_down_d  = 1'b0;
      dwell_cnt_d = '0;
      blank_cnt_d = '0;
      dwell_lat_d = dwell_eff;
      state_d     = bus_if.run ? SHOW : IDLE;
      en_d        = bus_if.run;
    end else begin
      case (state_q)
        IDLE: begin
          en_d = 1'b0;
          if (bus_if.run) begin
            state_d     = SHOW;
            en_d        = 1'b1;
            dwell_lat_d = dwell_eff;
            dwell_cnt_d = '0;
          end
        end
        SHOW: begin
          if (!bus_if.run) begin
            state_d     = IDLE;
            en_d        = 1'b0;
            dwell_cnt_d = '0;
            blank_cnt_d = '0;
          end else if (pos_done) begin
            add_d       = adv_add;
            dir_down_d  = adv_dir_down;
            wrap_d      = (adv_add == 3'd0);
            dwell_cnt_d = '0;
            if (HAS_BLANK) begin
              // Address moves on the same edge enable drops, so it never changes while lit.
              state_d     = BLANK;
              en_d        = 1'b0;
              blank_cnt_d = '0;
            end else begin
              en_d        = 1'b1;
              dwell_lat_d = dwell_eff;
            end
          end else begin
            dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
          end
        end
        BLANK: begin
          if (!bus_if.run) begin
            state_d     = IDLE;
            en_d        = 1'b0;
            dwell_cnt_d = '0;
            blank_cnt_d = '0;
          end else if (blank_cnt_q == BLANK_LAST) begin
            state_d     = SHOW;
            en_d        = 1'b1;
            dwell_lat_d = dwell_eff;
            dwell_cnt_d = '0;
            blank_cnt_d = '0;
          end else begin
            blank_cnt_d = blank_cnt_q + BLANK_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          en_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      en_q        <= 1'b0;
      add_q       <= 3'd0;
      wrap_q      <= 1'b0;
      dir_down_q  <= 1'b0;
      dwell_cnt_q <= '0;
      dwell_lat_q <= DWELL_W'(1);
      blank_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      add_q       <= add_d;
      wrap_q      <= wrap_d;
      dir_down_q  <= dir_down_d;
      dwell_cnt_q <= dwell_cnt_d;
      dwell_lat_q <= dwell_lat_d;
      blank_cnt_q <= blank_cnt_d;
    end
  end

  assign bus_if.en   = en_q;
  assign bus_if.add  = add_q;
  assign bus_if.wrap = wrap_q;
  assign bus_if.busy = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_scan_addr_gen.sv
`default_nettype none
// tb_scan_addr_gen: randomized scan sequences against a position-list reference model.
// Revision: 1.0
module tb_scan_addr_gen;

  localparam int DW = 16;

  typedef struct packed {
    logic       en;
    logic [2:0] add;
    logic       wrap;
    logic       busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passes = 0;

  exp_t exp_b[$];
  exp_t exp_n[$];

  scan_addr_gen_if #(.DWELL_W(DW)) bus_b ();
  scan_addr_gen_if #(.DWELL_W(DW)) bus_n ();

  scan_addr_gen #(.DWELL_W(DW), .BLANK_CYC(2), .BLANK_W(4)) u_dut_blank (
    .clk(clk), .rst(rst), .bus_if(bus_b)
  );
  scan_addr_gen #(.DWELL_W(DW), .BLANK_CYC(0), .BLANK_W(4)) u_dut_noblank (
    .clk(clk), .rst(rst), .bus_if(bus_n)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Position shown at scan step k starting from address 0 going up.
  function automatic int pos_of(int m, int k);
    int r;
    r = k % 14;
    if (m != 0) return (r < 8) ? r : 14 - r;
    return k % 8;
  endfunction

  function automatic void push(bit sel, exp_t e);
    if (sel) exp_n.push_back(e);
    else     exp_b.push_back(e);
  endfunction

  // Expected per-cycle outputs for steps k0..k1; step k0 is entered directly (no advance).
  function automatic void build(bit sel, int m, int k0, int k1, int blank, int l_first, int l_rest);
    int   p;
    int   l;
    exp_t e;
    for (int k = k0; k <= k1; k++) begin
      p = pos_of(m, k);
      l = (k == k0) ? l_first : l_rest;
      if (l < 1) l = 1;
      if (k > k0) begin
        for (int b = 0; b < blank; b++) begin
          e.en = 1'b0; e.add = 3'(p); e.wrap = (b == 0 && p == 0); e.busy = 1'b1;
          push(sel, e);
        end
      end
      for (int c = 0; c < l; c++) begin
        e.en = 1'b1; e.add = 3'(p); e.wrap = (blank == 0 && c == 0 && k > k0 && p == 0); e.busy = 1'b1;
        push(sel, e);
      end
    end
  endfunction

  task automatic drive(input logic run, input logic clr, input logic mode, input int dwell);
    bus_b.run = run; bus_b.clr = clr; bus_b.mode = mode; bus_b.dwell = DW'(dwell);
    bus_n.run = run; bus_n.clr = clr; bus_n.mode = mode; bus_n.dwell = DW'(dwell);
  endtask

  task automatic apply_reset();
    drive(1'b0, 1'b0, 1'b0, 1);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_b.delete();
    exp_n.delete();
  endtask

  task automatic test_reset();
    logic [5:0] ob, on;
    drive(1'b0, 1'b0, 1'b0, 1);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      ob = {bus_b.en, bus_b.add, bus_b.wrap, bus_b.busy};
      on = {bus_n.en, bus_n.add, bus_n.wrap, bus_n.busy};
      checks++;
      if (ob !== 6'b0) $display("FAIL reset_blank step=%0d got=%b exp=%b", i, ob, 6'b0);
      else passes++;
      checks++;
      if (on !== 6'b0) $display("FAIL reset_noblank step=%0d got=%b exp=%b", i, on, 6'b0);
      else passes++;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_scan(input int m, input int d, input int npos);
    exp_t       e;
    logic [5:0] o;
    int         cyc;
    apply_reset();
    build(1'b0, m, 0, npos - 1, 2, d, d);
    build(1'b1, m, 0, npos - 1, 0, d, d);
    drive(1'b1, 1'b0, 1'(m), d);
    cyc = 0;
    while (exp_b.size() > 0 || exp_n.size() > 0) begin
      @(negedge clk);
      if (exp_b.size() > 0) begin
        e = exp_b.pop_front();
        o = {bus_b.en, bus_b.add, bus_b.wrap, bus_b.busy};
        checks++;
        if (o !== e) $display("FAIL scan_blank m=%0d d=%0d cyc=%0d got=%b exp=%b (en,add,wrap,busy)", m, d, cyc, o, e);
        else passes++;
      end
      if (exp_n.size() > 0) begin
        e = exp_n.pop_front();
        o = {bus_n.en, bus_n.add, bus_n.wrap, bus_n.busy};
        checks++;
        if (o !== e) $display("FAIL scan_noblank m=%0d d=%0d cyc=%0d got=%b exp=%b (en,add,wrap,busy)", m, d, cyc, o, e);
        else passes++;
      end
      cyc++;
    end
    drive(1'b0, 1'b0, 1'b0, 1);
  endtask

  task automatic test_dwell_change();
    exp_t       e;
    logic [5:0] o;
    int         cyc;
    apply_reset();
    build(1'b0, 0, 0, 3, 2, 3, 5);
    build(1'b1, 0, 0, 3, 0, 3, 5);
    drive(1'b1, 1'b0, 1'b0, 3);
    cyc = 0;
    while (exp_b.size() > 0 || exp_n.size() > 0) begin
      @(negedge clk);
      if (exp_b.size() > 0) begin
        e = exp_b.pop_front();
        o = {bus_b.en, bus_b.add, bus_b.wrap, bus_b.busy};
        checks++;
        if (o !== e) $display("FAIL dwell_change_blank cyc=%0d got=%b exp=%b", cyc, o, e);
        else passes++;
      end
      if (exp_n.size() > 0) begin
        e = exp_n.pop_front();
        o = {bus_n.en, bus_n.add, bus_n.wrap, bus_n.busy};
        checks++;
        if (o !== e) $display("FAIL dwell_change_noblank cyc=%0d got=%b exp=%b", cyc, o, e);
        else passes++;
      end
      if (cyc == 0) drive(1'b1, 1'b0, 1'b0, 5);
      cyc++;
    end
    drive(1'b0, 1'b0, 1'b0, 1);
  endtask

  task automatic test_run_drop();
    exp_t       e;
    logic [5:0] o;
    exp_t       halt;
    apply_reset();
    build(1'b0, 0, 0, 7, 2, 3, 3);
    drive(1'b1, 1'b0, 1'b0, 3);
    e = '0;
    while (exp_b.size() > 0 && !(e.en && e.add == 3'd5)) begin
      @(negedge clk);
      e = exp_b.pop_front();
      o = {bus_b.en, bus_b.add, bus_b.wrap, bus_b.busy};
      checks++;
      if (o !== e) $display("FAIL run_drop_pre got=%b exp=%b", o, e);
      else passes++;
    end
    exp_b.delete();
    drive(1'b0, 1'b0, 1'b0, 3);
    halt.en = 1'b0; halt.add = 3'd5; halt.wrap = 1'b0; halt.busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      o = {bus_b.en, bus_b.add, bus_b.wrap, bus_b.busy};
      checks++;
      if (o !== halt) $display("FAIL run_drop_halt i=%0d got=%b exp=%b", i, o, halt);
      else passes++;
    end
    build(1'b0, 0, 5, 7, 2, 3, 3);
    drive(1'b1, 1'b0, 1'b0, 3);
    while (exp_b.size() > 0) begin
      @(negedge clk);
      e = exp_b.pop_front();
      o = {bus_b.en, bus_b.add, bus_b.wrap, bus_b.busy};
      checks++;
      if (o !== e) $display("FAIL run_drop_resume got=%b exp=%b", o, e);
      else passes++;
    end
    drive(1'b0, 1'b0, 1'b0, 1);
  endtask

  task automatic test_clr();
    exp_t       e;
    logic [5:0] o;
    int         cyc;
    apply_reset();
    build(1'b0, 0, 0, 7, 2, 2, 2);
    drive(1'b1, 1'b0, 1'b0, 2);
    e = '1;
    while (exp_b.size() > 0 && !(!e.en && e.add == 3'd3)) begin
      @(negedge clk);
      e = exp_b.pop_front();
      o = {bus_b.en, bus_b.add, bus_b.wrap, bus_b.busy};
      checks++;
      if (o !== e) $display("FAIL clr_pre got=%b exp=%b", o, e);
      else passes++;
    end
    exp_b.delete();
    drive(1'b1, 1'b1, 1'b0, 2);
    build(1'b0, 0, 0, 2, 2, 2, 2);
    cyc = 0;
    while (exp_b.size() > 0) begin
      @(negedge clk);
      e = exp_b.pop_front();
      o = {bus_b.en, bus_b.add, bus_b.wrap, bus_b.busy};
      checks++;
      if (o !== e) $display("FAIL clr_post cyc=%0d got=%b exp=%b", cyc, o, e);
      else passes++;
      if (cyc == 0) drive(1'b1, 1'b0, 1'b0, 2);
      cyc++;
    end
    drive(1'b0, 1'b0, 1'b0, 1);
  endtask

  task automatic test_async_rst();
    exp_t       e;
    logic [5:0] o;
    int         m;
    m = int'($urandom_range(0, 1));
    apply_reset();
    build(1'b0, m, 0, 6, 2, 3, 3);
    drive(1'b1, 1'b0, 1'(m), 3);
    e = '0;
    while (exp_b.size() > 0 && !(e.en && e.add == 3'd4)) begin
      @(negedge clk);
      e = exp_b.pop_front();
      o = {bus_b.en, bus_b.add, bus_b.wrap, bus_b.busy};
      checks++;
      if (o !== e) $display("FAIL async_rst_pre got=%b exp=%b", o, e);
      else passes++;
    end
    #2;
    rst = 1'b1;
    #1;
    o = {bus_b.en, bus_b.add, bus_b.wrap, bus_b.busy};
    checks++;
    if (o !== 6'b0) $display("FAIL async_rst_blank got=%b exp=%b", o, 6'b0);
    else passes++;
    o = {bus_n.en, bus_n.add, bus_n.wrap, bus_n.busy};
    checks++;
    if (o !== 6'b0) $display("FAIL async_rst_noblank got=%b exp=%b", o, 6'b0);
    else passes++;
    drive(1'b0, 1'b0, 1'b0, 1);
    @(negedge clk);
    rst = 1'b0;
    exp_b.delete();
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1);
    test_reset();
    test_scan(0, 4, 16);
    test_scan(0, 1, 17);
    test_scan(1, 2, 16);
    test_scan(0, 0, 9);
    for (int i = 0; i < 3; i++)
      test_scan(int'($urandom_range(0, 1)), int'($urandom_range(0, 6)), 16);
    test_dwell_change();
    test_run_drop();
    test_clr();
    test_async_rst();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
